// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad BCD calculator sequencer.
// Holds the FSM state encoding, special key codes and display-select codes.
package calc_pkg;

    typedef enum logic [1:0] {
        ENTER_A  = 2'd0,
        ENTER_B  = 2'd1,
        SHOW_SUM = 2'd2
    } state_t;

    localparam logic [3:0] KEY_PLUS = 4'hA;
    localparam logic [3:0] KEY_EQ   = 4'hB;
    localparam logic [3:0] KEY_CLR  = 4'hC;

    localparam logic [1:0] SEL_A   = 2'b00;
    localparam logic [1:0] SEL_B   = 2'b01;
    localparam logic [1:0] SEL_SUM = 2'b10;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'h9;
    endfunction

    function automatic logic [1:0] sel_of(input state_t st);
        case (st)
            ENTER_B:  return SEL_B;
            SHOW_SUM: return SEL_SUM;
            default:  return SEL_A;
        endcase
    endfunction

endpackage

// File: rtl/module_bcd_entry_reg.sv
// One BCD operand register with left-shift digit entry and saturation check.
// The digit count lives in the sequencer; this block only compares against it.
module module_bcd_entry_reg #(
    parameter int MAX_DIGITS = 3,
    parameter int DIGIT_W    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          shift_en,
    input  logic [DIGIT_W-1:0]            digit,
    input  logic                          preload_en,
    input  logic [MAX_DIGITS*DIGIT_W-1:0] preload_val,
    input  logic [1:0]                    cnt,
    output logic [MAX_DIGITS*DIGIT_W-1:0] value,
    output logic                          full
);

    localparam int         OP_W    = MAX_DIGITS * DIGIT_W;
    localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

    logic [OP_W-1:0] value_d, value_q;

    assign full  = (cnt >= MAX_CNT);
    assign value = value_q;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (preload_en) begin
            value_d = preload_val;
        end else if (shift_en && !full) begin
            value_d = {value_q[OP_W-DIGIT_W-1:0], digit};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/module_calc_ctrl.sv
// Central sequencer for the keypad BCD adder: key press detection, operand
// entry for A and B, and result display control.
module module_calc_ctrl
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 3,
    parameter int DIGIT_W    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          key_valid,
    input  logic [3:0]                    key_code,
    output logic [MAX_DIGITS*DIGIT_W-1:0] operand_a,
    output logic [MAX_DIGITS*DIGIT_W-1:0] operand_b,
    output logic [1:0]                    disp_sel,
    output logic                          sum_valid,
    output logic [1:0]                    digit_cnt,
    output logic                          err
);

    localparam int OP_W = MAX_DIGITS * DIGIT_W;

    state_t          state_d, state_q;
    logic [1:0]      digit_cnt_d, digit_cnt_q;
    logic            err_d, err_q;
    logic [1:0]      disp_sel_d, disp_sel_q;
    logic            sum_valid_d, sum_valid_q;
    logic            key_valid_q, armed_d, armed_q;
    logic            press;
    logic            a_clr, a_shift, a_pre, a_full;
    logic            b_clr, b_shift, b_full;
    logic [OP_W-1:0] digit_ext;

    // armed_q stays low after reset until the key is seen released, so a key
    // held through reset never produces a press.
    assign press     = key_valid & ~key_valid_q & armed_q;
    assign armed_d   = armed_q | ~key_valid;
    assign digit_ext = OP_W'(key_code);

    always_comb begin
        state_d     = state_q;
        digit_cnt_d = digit_cnt_q;
        err_d       = 1'b0;
        a_clr       = 1'b0;
        a_shift     = 1'b0;
        a_pre       = 1'b0;
        b_clr       = 1'b0;
        b_shift     = 1'b0;
        if (press) begin
            if (key_code == KEY_CLR) begin
                state_d     = ENTER_A;
                digit_cnt_d = 2'd0;
                a_clr       = 1'b1;
                b_clr       = 1'b1;
            end else if (key_code > KEY_CLR) begin
                err_d = 1'b1;
            end else begin
                case (state_q)
                    ENTER_A: begin
                        if (is_digit(key_code)) begin
                            if (a_full) begin
                                err_d = 1'b1;
                            end else begin
                                a_shift     = 1'b1;
                                digit_cnt_d = digit_cnt_q + 2'd1;
                            end
                        end else if (key_code == KEY_PLUS) begin
                            state_d     = ENTER_B;
                            digit_cnt_d = 2'd0;
                            b_clr       = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    ENTER_B: begin
                        if (is_digit(key_code)) begin
                            if (b_full) begin
                                err_d = 1'b1;
                            end else begin
                                b_shift     = 1'b1;
                                digit_cnt_d = digit_cnt_q + 2'd1;
                            end
                        end else if (key_code == KEY_EQ) begin
                            state_d = SHOW_SUM;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    SHOW_SUM: begin
                        // A digit starts a fresh sum; '+' chains onto A.
                        if (is_digit(key_code)) begin
                            state_d     = ENTER_A;
                            digit_cnt_d = 2'd1;
                            a_pre       = 1'b1;
                            b_clr       = 1'b1;
                        end else if (key_code == KEY_PLUS) begin
                            state_d     = ENTER_B;
                            digit_cnt_d = 2'd0;
                            b_clr       = 1'b1;
                        end
                    end
                    default: begin
                        state_d = ENTER_A;
                    end
                endcase
            end
        end
        disp_sel_d  = sel_of(state_d);
        sum_valid_d = (state_d == SHOW_SUM);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ENTER_A;
            digit_cnt_q <= 2'd0;
            err_q       <= 1'b0;
            disp_sel_q  <= SEL_A;
            sum_valid_q <= 1'b0;
            key_valid_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_cnt_q <= digit_cnt_d;
            err_q       <= err_d;
            disp_sel_q  <= disp_sel_d;
            sum_valid_q <= sum_valid_d;
            key_valid_q <= key_valid;
            armed_q     <= armed_d;
        end
    end

    module_bcd_entry_reg #(.MAX_DIGITS(MAX_DIGITS), .DIGIT_W(DIGIT_W)) u_reg_a (
        .clk         (clk),
        .rst         (rst),
        .clr         (a_clr),
        .shift_en    (a_shift),
        .digit       (DIGIT_W'(key_code)),
        .preload_en  (a_pre),
        .preload_val (digit_ext),
        .cnt         (digit_cnt_q),
        .value       (operand_a),
        .full        (a_full)
    );

    module_bcd_entry_reg #(.MAX_DIGITS(MAX_DIGITS), .DIGIT_W(DIGIT_W)) u_reg_b (
        .clk         (clk),
        .rst         (rst),
        .clr         (b_clr),
        .shift_en    (b_shift),
        .digit       (DIGIT_W'(key_code)),
        .preload_en  (1'b0),
        .preload_val ('0),
        .cnt         (digit_cnt_q),
        .value       (operand_b),
        .full        (b_full)
    );

    assign digit_cnt = digit_cnt_q;
    assign err       = err_q;
    assign disp_sel  = disp_sel_q;
    assign sum_valid = sum_valid_q;

endmodule

// File: tb/tb_module_calc_ctrl.sv
// Directed testbench for module_calc_ctrl with hand-computed expectations
// checked by immediate assertions.
module tb_module_calc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic [11:0] operand_a, operand_b;
    logic [1:0]  disp_sel, digit_cnt;
    logic        sum_valid, err;

    int   checks = 0;
    int   errors = 0;
    logic err_first, err_second;

    always #5 clk = ~clk;

    module_calc_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .disp_sel  (disp_sel),
        .sum_valid (sum_valid),
        .digit_cnt (digit_cnt),
        .err       (err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One key press: err is captured on the cycle after the press and one cycle later.
    task automatic applyStimulus(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        err_first = err;
        key_valid = 1'b0;
        @(negedge clk);
        err_second = err;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_a"},   operand_a, 12'h000);
        checkOutput({tag, "_b"},   operand_b, 12'h000);
        checkOutput({tag, "_sel"}, disp_sel,  2'b00);
        checkOutput({tag, "_sv"},  sum_valid, 1'b0);
        checkOutput({tag, "_cnt"}, digit_cnt, 2'd0);
        checkOutput({tag, "_err"}, err,       1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b1;
        checkIdle("reset");

        // Basic A + B entry
        applyStimulus(4'h1); checkOutput("t1_cnt1", digit_cnt, 2'd1);
        applyStimulus(4'h2); checkOutput("t1_cnt2", digit_cnt, 2'd2);
        applyStimulus(4'h3); checkOutput("t1_cnt3", digit_cnt, 2'd3);
        checkOutput("t1_a_entry", operand_a, 12'h123);
        applyStimulus(4'hA); checkOutput("t1_cnt0", digit_cnt, 2'd0);
        checkOutput("t1_sel_b", disp_sel, 2'b01);
        applyStimulus(4'h4); checkOutput("t1_cnt4", digit_cnt, 2'd1);
        applyStimulus(4'h5); checkOutput("t1_cnt5", digit_cnt, 2'd2);
        applyStimulus(4'hB);
        checkOutput("t1_a", operand_a, 12'h123);
        checkOutput("t1_b", operand_b, 12'h045);
        checkOutput("t1_sel", disp_sel, 2'b10);
        checkOutput("t1_sv", sum_valid, 1'b1);

        // Chain from the result, then start a new calculation
        applyStimulus(4'hA);
        checkOutput("t4_chain_sel", disp_sel, 2'b01);
        checkOutput("t4_chain_b", operand_b, 12'h000);
        checkOutput("t4_chain_sv", sum_valid, 1'b0);
        applyStimulus(4'h7);
        applyStimulus(4'hB);
        checkOutput("t4_a", operand_a, 12'h123);
        checkOutput("t4_b", operand_b, 12'h007);
        checkOutput("t4_sv", sum_valid, 1'b1);
        applyStimulus(4'hB);
        checkOutput("t4_eq_noerr", err_first, 1'b0);
        checkOutput("t4_eq_hold", disp_sel, 2'b10);
        applyStimulus(4'h2);
        checkOutput("t4_new_a", operand_a, 12'h002);
        checkOutput("t4_new_b", operand_b, 12'h000);
        checkOutput("t4_new_sel", disp_sel, 2'b00);
        checkOutput("t4_new_cnt", digit_cnt, 2'd1);
        checkOutput("t4_new_sv", sum_valid, 1'b0);

        // Saturation at MAX_DIGITS
        doReset();
        applyStimulus(4'h9);
        applyStimulus(4'h8);
        applyStimulus(4'h7);
        checkOutput("t2_noerr", err_first, 1'b0);
        applyStimulus(4'h6);
        checkOutput("t2_err_pulse", err_first, 1'b1);
        checkOutput("t2_err_end", err_second, 1'b0);
        checkOutput("t2_a", operand_a, 12'h987);
        checkOutput("t2_cnt", digit_cnt, 2'd3);

        // Invalid and out-of-place keys
        applyStimulus(4'hB);
        checkOutput("t5_eqA_err", err_first, 1'b1);
        checkOutput("t5_eqA_sel", disp_sel, 2'b00);
        checkOutput("t5_eqA_a", operand_a, 12'h987);
        applyStimulus(4'hA);
        applyStimulus(4'hE);
        checkOutput("t5_invB_err", err_first, 1'b1);
        checkOutput("t5_invB_sel", disp_sel, 2'b01);
        checkOutput("t5_invB_b", operand_b, 12'h000);
        applyStimulus(4'hA);
        checkOutput("t5_plusB_err", err_first, 1'b1);
        checkOutput("t5_plusB_sel", disp_sel, 2'b01);
        checkOutput("t5_plusB_a", operand_a, 12'h987);
        applyStimulus(4'h1);
        checkOutput("t5_b_digit", operand_b, 12'h001);

        // Clear mid-B
        applyStimulus(4'hC);
        checkOutput("t6_clr_errq", err_first, 1'b0);
        checkIdle("t6_clr");

        // Long hold counts once
        doReset();
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'h5;
        repeat (20) @(negedge clk);
        checkOutput("t3_a", operand_a, 12'h005);
        checkOutput("t3_cnt", digit_cnt, 2'd1);
        key_valid = 1'b0;
        @(negedge clk);

        // Reset while a key is held
        doReset();
        applyStimulus(4'h4);
        applyStimulus(4'h5);
        applyStimulus(4'hA);
        checkOutput("t6_pre_sel", disp_sel, 2'b01);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'h7;
        rst       = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checkIdle("t6_rst");
        repeat (5) @(negedge clk);
        checkOutput("t6_held_a", operand_a, 12'h000);
        checkOutput("t6_held_cnt", digit_cnt, 2'd0);
        key_valid = 1'b0;
        @(negedge clk);
        applyStimulus(4'h8);
        checkOutput("t6_rearm_a", operand_a, 12'h008);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
